concat_pack_sequencer: RTL and testbench

//  Streaming controller for the concatenation/replication datapath. Accepts DATA_W-bit elements over

---
 rtl/concat_pack_sequencer.sv | 160 ++++++++++++++++
 tb/tb_concat_pack_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/concat_pack_sequencer.sv
// Streaming element-to-word sequencer with PACK / SPLAT / PAIR modes and flush of partial PACK words.
// Optional statistics counters are enabled with the CONCAT_SEQ_STATS_EN macro.
module concat_pack_sequencer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4,
  localparam int OUT_W = DATA_W * LANES,
  localparam int CW    = $clog2(LANES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  input  logic              out_ready,
  output logic [CW-1:0]     out_count
`ifdef CONCAT_SEQ_STATS_EN
  ,
  output logic [15:0]       word_cnt,
  output logic [7:0]        flush_cnt
`endif
);

  localparam logic [1:0] MODE_PACK  = 2'b00;
  localparam logic [1:0] MODE_SPLAT = 2'b01;
  localparam logic [1:0] MODE_PAIR  = 2'b10;

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT} state_t;

  state_t             state_reg;
  logic [1:0]         mode_reg;
  logic [CW-1:0]      count_reg;
  logic [OUT_W-1:0]   pack_reg;
  logic [OUT_W-1:0]   pack_next;
  logic [OUT_W-1:0]   splat_word;
  logic [OUT_W-1:0]   pair_word;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic [OUT_W-1:0]   out_data_reg;
  logic [CW-1:0]      out_count_reg;
  logic               accept;
  logic [1:0]         mode_eff;
  logic [CW-1:0]      count_inc;
  logic               pack_full;
  logic               pair_full;
  logic               flush_take;

  assign accept    = in_valid && in_ready_reg;
  assign mode_eff  = (mode == 2'b11) ? MODE_PACK : mode;
  assign count_inc = count_reg + 1'b1;
  assign pack_full = (state_reg == COLLECT) && accept && (mode_reg == MODE_PACK)
                     && (count_inc == CW'(LANES));
  assign pair_full = (state_reg == COLLECT) && accept && (mode_reg == MODE_PAIR)
                     && (count_inc == CW'(2));
  // A flush that coincides with the final element just yields the normal full word.
  assign flush_take = (state_reg == COLLECT) && (mode_reg == MODE_PACK) && flush && !pack_full;

  always_comb begin
    pack_next = (state_reg == IDLE) ? '0 : pack_reg;
    for (int i = 0; i < LANES; i++) begin
      if (accept && count_reg == CW'(i))
        pack_next[OUT_W-1-i*DATA_W -: DATA_W] = in_data;
    end
  end

  // First element lands in the MSB lane; PAIR puts e0 above e1 in every pair.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_splat
    assign splat_word[gi*DATA_W +: DATA_W] = in_data;
  end
  for (genvar gi = 0; gi < LANES / 2; gi++) begin : g_pair
    assign pair_word[(2*gi+1)*DATA_W +: DATA_W] = pack_reg[OUT_W-1 -: DATA_W];
    assign pair_word[(2*gi)*DATA_W +: DATA_W]   = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      mode_reg      <= MODE_PACK;
      count_reg     <= '0;
      pack_reg      <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          in_ready_reg <= 1'b1;
          if (accept) begin
            mode_reg  <= mode_eff;
            count_reg <= CW'(1);
            pack_reg  <= pack_next;
            if (mode_eff == MODE_SPLAT) begin
              out_data_reg  <= splat_word;
              out_count_reg <= CW'(LANES);
              out_valid_reg <= 1'b1;
              in_ready_reg  <= 1'b0;
              state_reg     <= EMIT;
            end else begin
              state_reg <= COLLECT;
            end
          end
        end
        COLLECT: begin
          if (accept) begin
            count_reg <= count_inc;
            pack_reg  <= pack_next;
          end
          if (pair_full || pack_full || flush_take) begin
            out_data_reg  <= pair_full ? pair_word : pack_next;
            out_count_reg <= (pair_full || pack_full) ? CW'(LANES)
                             : (accept ? count_inc : count_reg);
            out_valid_reg <= 1'b1;
            in_ready_reg  <= 1'b0;
            state_reg     <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            count_reg     <= '0;
            pack_reg      <= '0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_count = out_count_reg;

`ifdef CONCAT_SEQ_STATS_EN
  logic [15:0] word_cnt_reg;
  logic [7:0]  flush_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      word_cnt_reg  <= '0;
      flush_cnt_reg <= '0;
    end else begin
      if (out_valid_reg && out_ready)
        word_cnt_reg <= word_cnt_reg + 16'd1;
      if (flush_take && flush_cnt_reg != 8'hFF)
        flush_cnt_reg <= flush_cnt_reg + 8'd1;
    end
  end

  assign word_cnt  = word_cnt_reg;
  assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_concat_pack_sequencer.sv
// Directed-vector bench for concat_pack_sequencer (DATA_W=8, LANES=4) with hand-computed words.
// Stats ports are exercised when CONCAT_SEQ_STATS_EN is defined.
module tb_concat_pack_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        flush;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic [2:0]  out_count;
`ifdef CONCAT_SEQ_STATS_EN
  logic [15:0] word_cnt;
  logic [7:0]  flush_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int exp_words = 0;
  int exp_flushes = 0;

  always #5 clk = ~clk;

  concat_pack_sequencer #(.DATA_W(8), .LANES(4)) dut (
    .clk(clk), .rst(rst), .mode(mode), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_count(out_count)
`ifdef CONCAT_SEQ_STATS_EN
    , .word_cnt(word_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Present one element (optionally with flush) and hold it until accepted; returns #1 after the edge.
  task automatic send(input logic [7:0] d, input logic [1:0] m, input logic f);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; mode = m; flush = f;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("send_timeout", 64'(n), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic take(input string tag, input logic [31:0] exp_data, input logic [2:0] exp_cnt);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(out_data), 64'(exp_data));
    check({tag, "_count"}, 64'(out_count), 64'(exp_cnt));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    exp_words++;
    check({tag, "_drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_count", 64'(out_count), 64'd0);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("idle_in_ready", 64'(in_ready), 64'd1);

    // PACK with exact latency check
    send(8'hAA, 2'b00, 1'b0);
    send(8'h55, 2'b00, 1'b0);
    send(8'h0F, 2'b00, 1'b0);
    check("pack_early", 64'(out_valid), 64'd0);
    send(8'hF0, 2'b00, 1'b0);
    check("pack_in_ready", 64'(in_ready), 64'd0);
    take("pack", 32'hAA550FF0, 3'd4);

    // SPLAT, then a PACK word unaffected by it
    send(8'hAA, 2'b01, 1'b0);
    take("splat", 32'hAAAAAAAA, 3'd4);
    send(8'h01, 2'b00, 1'b0);
    send(8'h02, 2'b01, 1'b0);
    send(8'h03, 2'b10, 1'b0);
    send(8'h04, 2'b00, 1'b0);
    take("after_splat", 32'h01020304, 3'd4);

    // PAIR with a mid-word mode change ignored
    send(8'hAA, 2'b10, 1'b0);
    send(8'h05, 2'b00, 1'b0);
    take("pair", 32'hAA05AA05, 3'd4);

    // Reserved mode behaves as PACK
    send(8'hDE, 2'b11, 1'b0);
    send(8'hAD, 2'b01, 1'b0);
    send(8'hBE, 2'b01, 1'b0);
    send(8'hEF, 2'b01, 1'b0);
    take("mode11", 32'hDEADBEEF, 3'd4);

    // Flush of a partial PACK word
    send(8'h12, 2'b00, 1'b0);
    send(8'h34, 2'b00, 1'b0);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    exp_flushes++;
    take("flush2", 32'h12340000, 3'd2);

    // Flush in IDLE is ignored
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("flush_idle", 64'(out_valid), 64'd0);

    // Flush together with an accept counts that element
    send(8'h56, 2'b00, 1'b0);
    send(8'h78, 2'b00, 1'b1);
    exp_flushes++;
    take("flush_acc", 32'h56780000, 3'd2);

    // Flush together with the last element gives a normal full word
    send(8'h11, 2'b00, 1'b0);
    send(8'h22, 2'b00, 1'b0);
    send(8'h33, 2'b00, 1'b0);
    send(8'h44, 2'b00, 1'b1);
    take("flush_full", 32'h11223344, 3'd4);

    // Flush during PAIR collection is ignored
    send(8'h9C, 2'b10, 1'b0);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_pair", 64'(out_valid), 64'd0);
    send(8'h3E, 2'b00, 1'b0);
    take("pair2", 32'h9C3E9C3E, 3'd4);

`ifdef CONCAT_SEQ_STATS_EN
    check("word_cnt", 64'(word_cnt), 64'(exp_words));
    check("flush_cnt", 64'(flush_cnt), 64'(exp_flushes));
`endif

    // Back-pressure: word held stable for 5 stalled cycles
    send(8'h9A, 2'b00, 1'b0);
    send(8'hBC, 2'b00, 1'b0);
    send(8'hDE, 2'b00, 1'b0);
    send(8'hF0, 2'b00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_data", 64'(out_data), 64'h9ABCDEF0);
      check("stall_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b1; in_data = 8'h77;
    @(posedge clk); #1; in_valid = 1'b0;
    take("stall", 32'h9ABCDEF0, 3'd4);

    // Reset mid-COLLECT discards the partial word
    send(8'hC1, 2'b00, 1'b0);
    send(8'hC2, 2'b00, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_valid", 64'(out_valid), 64'd0);
    check("rst_mid_ready", 64'(in_ready), 64'd0);
    @(negedge clk); rst = 1'b0;
    send(8'hD1, 2'b00, 1'b0);
    send(8'hD2, 2'b00, 1'b0);
    send(8'hD3, 2'b00, 1'b0);
    send(8'hD4, 2'b00, 1'b0);
    take("post_rst", 32'hD1D2D3D4, 3'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
